// File: rtl/l2_arbiter.sv
// Two-way arbiter sharing one L2 line port between the L1 I-cache and D-cache.
// One latched 256-bit transaction at a time; a DRAIN cycle separates transactions.
module l2_arbiter #(
  parameter int LINE_W     = 256,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int D_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic             D_WINS  = (D_PRIORITY != 32'sd0);

  state_t              state_r, state_s;
  logic                last_d_r;
  logic                grant_i_s, grant_d_s, d_req_s;
  logic                l2_read_r, l2_write_r;
  logic [ADDR_W-1:0]   l2_addr_r;
  logic [LINE_W-1:0]   l2_wdata_r;
  logic [CNT_W-1:0]    i_cnt_r, d_cnt_r;
  logic                unused_s;

  assign d_req_s  = d_read | d_write;
  // Line offset bits never reach the L2; they are zeroed when latched.
  assign unused_s = ^{i_addr[4:0], d_addr[4:0]};

  // Arbitration among sampled requests and next-state selection.
  always_comb begin
    state_s   = state_r;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_read && d_req_s) begin
          if (D_WINS || !last_d_r) grant_d_s = 1'b1;
          else                     grant_i_s = 1'b1;
        end else if (i_read) begin
          grant_i_s = 1'b1;
        end else if (d_req_s) begin
          grant_d_s = 1'b1;
        end else begin
          grant_i_s = 1'b0;
        end
        if (grant_i_s)      state_s = ST_BUSY_I;
        else if (grant_d_s) state_s = ST_BUSY_D;
        else                state_s = ST_IDLE;
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (l2_resp) state_s = ST_DRAIN;
        else         state_s = state_r;
      end
      ST_DRAIN: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register, latched L2 request and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      last_d_r   <= 1'b1;
      l2_read_r  <= 1'b0;
      l2_write_r <= 1'b0;
      l2_addr_r  <= {ADDR_W{1'b0}};
      l2_wdata_r <= {LINE_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (grant_i_s) begin
        last_d_r   <= 1'b0;
        l2_read_r  <= 1'b1;
        l2_write_r <= 1'b0;
        l2_addr_r  <= {i_addr[ADDR_W-1:5], 5'b00000};
      end else if (grant_d_s) begin
        // A simultaneous read+write keeps the read and drops the write.
        last_d_r   <= 1'b1;
        l2_read_r  <= d_read;
        l2_write_r <= d_write & ~d_read;
        l2_addr_r  <= {d_addr[ADDR_W-1:5], 5'b00000};
        l2_wdata_r <= d_wdata;
      end else if (state_s == ST_DRAIN) begin
        l2_read_r  <= 1'b0;
        l2_write_r <= 1'b0;
      end
    end
  end

  // Saturating per-requester completion counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_cnt_r <= {CNT_W{1'b0}};
      d_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (i_resp && (i_cnt_r != CNT_MAX)) i_cnt_r <= i_cnt_r + CNT_ONE;
      if (d_resp && (d_cnt_r != CNT_MAX)) d_cnt_r <= d_cnt_r + CNT_ONE;
    end
  end

  // Protocol checks on requester and L2 handshakes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!((state_r == ST_IDLE) && d_read && d_write))
        else $warning("l2_arbiter: d_read and d_write both high, write dropped");
      assert (!(l2_resp && (state_r != ST_BUSY_I) && (state_r != ST_BUSY_D)))
        else $warning("l2_arbiter: l2_resp outside a transaction ignored");
    end
  end

  assign i_resp      = (state_r == ST_BUSY_I) & l2_resp;
  assign d_resp      = (state_r == ST_BUSY_D) & l2_resp;
  assign i_rdata     = l2_rdata;
  assign d_rdata     = l2_rdata;
  assign l2_read     = l2_read_r;
  assign l2_write    = l2_write_r;
  assign l2_addr     = l2_addr_r;
  assign l2_wdata    = l2_wdata_r;
  assign i_grant_cnt = i_cnt_r;
  assign d_grant_cnt = d_cnt_r;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: dut0 round-robin (16-bit counters), dut1 D-priority with 3-bit
// counters so saturation is reachable; responses are scoreboarded in a queue.
module tb_l2_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  typedef struct packed {
    logic          sel;
    logic          is_d;
    logic [AW-1:0] addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n    [2];
  logic          i_read   [2];
  logic [AW-1:0] i_addr   [2];
  logic [LW-1:0] i_rdata  [2];
  logic          i_resp   [2];
  logic          d_read   [2];
  logic          d_write  [2];
  logic [AW-1:0] d_addr   [2];
  logic [LW-1:0] d_wdata  [2];
  logic [LW-1:0] d_rdata  [2];
  logic          d_resp   [2];
  logic          l2_read  [2];
  logic          l2_write [2];
  logic [AW-1:0] l2_addr  [2];
  logic [LW-1:0] l2_wdata [2];
  logic [LW-1:0] l2_rdata [2];
  logic          l2_resp  [2];
  logic [15:0]   i_cnt    [2];
  logic [15:0]   d_cnt    [2];
  logic [2:0]    i_cnt1, d_cnt1;

  exp_t sb[$];
  int   i_m[2];
  int   d_m[2];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  assign i_cnt[1] = {13'd0, i_cnt1};
  assign d_cnt[1] = {13'd0, d_cnt1};

  l2_arbiter #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(16), .D_PRIORITY(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .i_read(i_read[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_resp(i_resp[0]),
    .d_read(d_read[0]), .d_write(d_write[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_resp(d_resp[0]),
    .l2_read(l2_read[0]), .l2_write(l2_write[0]), .l2_addr(l2_addr[0]), .l2_wdata(l2_wdata[0]),
    .l2_rdata(l2_rdata[0]), .l2_resp(l2_resp[0]),
    .i_grant_cnt(i_cnt[0]), .d_grant_cnt(d_cnt[0])
  );

  l2_arbiter #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(3), .D_PRIORITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .i_read(i_read[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_resp(i_resp[1]),
    .d_read(d_read[1]), .d_write(d_write[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_resp(d_resp[1]),
    .l2_read(l2_read[1]), .l2_write(l2_write[1]), .l2_addr(l2_addr[1]), .l2_wdata(l2_wdata[1]),
    .l2_rdata(l2_rdata[1]), .l2_resp(l2_resp[1]),
    .i_grant_cnt(i_cnt1), .d_grant_cnt(d_cnt1)
  );

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cnt_max(input int s);
    return (s == 0) ? 65535 : 7;
  endfunction

  // Queue the response the DUT owes and advance the reference counters.
  task automatic expect_txn(input int s, input logic is_d, input logic [AW-1:0] a);
    exp_t e;
    e.sel  = (s != 0);
    e.is_d = is_d;
    e.addr = a & 32'hFFFF_FFE0;
    sb.push_back(e);
    if (is_d) begin
      if (d_m[s] < cnt_max(s)) d_m[s]++;
    end else begin
      if (i_m[s] < cnt_max(s)) i_m[s]++;
    end
  endtask

  // Bench L2: wait for a request, hold it for 'delay' cycles checking stability, then respond.
  task automatic serve(input int s, input int delay);
    int n;
    logic [AW-1:0] a0;
    logic [LW-1:0] w0;
    logic [1:0]    f0;
    n = 0;
    @(negedge clk);
    while (!(l2_read[s] || l2_write[s]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("l2_req_seen", LW'(n < 50), LW'(1));
    a0 = l2_addr[s];
    w0 = l2_wdata[s];
    f0 = {l2_read[s], l2_write[s]};
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      check("stable_addr", LW'(l2_addr[s]), LW'(a0));
      check("stable_wdata", l2_wdata[s], w0);
      check("stable_flags", LW'({l2_read[s], l2_write[s]}), LW'(f0));
    end
    @(posedge clk); #1;
    l2_resp[s]  = 1'b1;
    l2_rdata[s] = {8{a0}};
    @(posedge clk); #1;
    l2_resp[s]  = 1'b0;
  endtask

  // In the DRAIN cycle: no request to the L2, no response, counters updated.
  task automatic after_txn(input int s);
    @(negedge clk);
    check("drain_gap", LW'({l2_read[s], l2_write[s]}), LW'(0));
    check("drain_no_resp", LW'({i_resp[s], d_resp[s]}), LW'(0));
    check("i_grant_cnt", LW'(i_cnt[s]), LW'(i_m[s]));
    check("d_grant_cnt", LW'(d_cnt[s]), LW'(d_m[s]));
  endtask

  // Scoreboard monitor: every resp pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (i_resp[s] || d_resp[s]) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", LW'({i_resp[s], d_resp[s]}), LW'(0));
        end else begin
          e = sb.pop_front();
          check("resp_dut", LW'(s), LW'(e.sel));
          check("resp_owner", LW'({d_resp[s], i_resp[s]}), LW'(e.is_d ? 2'b10 : 2'b01));
          check("resp_rdata", e.is_d ? d_rdata[s] : i_rdata[s], {8{e.addr}});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] pat;
    int n;
    pat = {8{32'hC3C3_5A5A}} ^ {32'h0123_4567, 192'd0, 32'h89AB_CDEF};
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; i_read[s] = 1'b0; i_addr[s] = '0; d_read[s] = 1'b0; d_write[s] = 1'b0;
      d_addr[s] = '0; d_wdata[s] = '0; l2_rdata[s] = '0; l2_resp[s] = 1'b0;
      i_m[s] = 0; d_m[s] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_l2_flags", LW'({l2_read[s], l2_write[s]}), LW'(0));
      check("rst_l2_addr", LW'(l2_addr[s]), LW'(0));
      check("rst_l2_wdata", l2_wdata[s], LW'(0));
      check("rst_resp", LW'({i_resp[s], d_resp[s]}), LW'(0));
      check("rst_cnts", LW'({i_cnt[s], d_cnt[s]}), LW'(0));
    end

    // Single I read, one-cycle request latency and address alignment.
    @(posedge clk); #1;
    i_read[0] = 1'b1; i_addr[0] = 32'h0000_1234;
    expect_txn(0, 1'b0, 32'h0000_1234);
    @(negedge clk);
    check("t1_idle_read", LW'(l2_read[0]), LW'(0));
    @(negedge clk);
    check("t1_l2_read", LW'({l2_read[0], l2_write[0]}), LW'(2'b10));
    check("t1_l2_addr", LW'(l2_addr[0]), LW'(32'h0000_1220));
    serve(0, 0);
    i_read[0] = 1'b0;
    after_txn(0);

    // D writeback held across a 10-cycle L2 delay.
    @(posedge clk); #1;
    d_write[0] = 1'b1; d_addr[0] = 32'h8000_0040; d_wdata[0] = pat;
    expect_txn(0, 1'b1, 32'h8000_0040);
    @(negedge clk);
    @(negedge clk);
    check("t2_l2_flags", LW'({l2_read[0], l2_write[0]}), LW'(2'b01));
    check("t2_l2_addr", LW'(l2_addr[0]), LW'(32'h8000_0040));
    check("t2_l2_wdata", l2_wdata[0], pat);
    serve(0, 10);
    d_write[0] = 1'b0;
    after_txn(0);

    // Held collision, round-robin: I, D, I, D.
    @(posedge clk); #1;
    i_read[0] = 1'b1; i_addr[0] = 32'h0000_0100;
    d_read[0] = 1'b1; d_addr[0] = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      expect_txn(0, (k % 2) == 1, (k % 2) == 1 ? 32'h0000_2000 : 32'h0000_0100);
      serve(0, k);
      if (k == 3) begin
        i_read[0] = 1'b0;
        d_read[0] = 1'b0;
      end
      after_txn(0);
    end

    // Address change while busy, then a spurious L2 response in IDLE.
    @(posedge clk); #1;
    i_read[0] = 1'b1; i_addr[0] = 32'h0000_4000;
    expect_txn(0, 1'b0, 32'h0000_4000);
    @(posedge clk); #1;
    i_addr[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t5_addr_held", LW'(l2_addr[0]), LW'(32'h0000_4000));
    serve(0, 3);
    i_read[0] = 1'b0;
    after_txn(0);
    @(posedge clk); #1;
    l2_resp[0] = 1'b1; l2_rdata[0] = {8{32'hFFFF_0000}};
    @(negedge clk);
    check("t5_spurious_resp", LW'({i_resp[0], d_resp[0]}), LW'(0));
    @(posedge clk); #1;
    l2_resp[0] = 1'b0;
    @(negedge clk);
    check("t5_i_cnt", LW'(i_cnt[0]), LW'(i_m[0]));
    check("t5_d_cnt", LW'(d_cnt[0]), LW'(d_m[0]));

    // Asynchronous reset in the middle of a D write.
    @(posedge clk); #1;
    d_write[0] = 1'b1; d_addr[0] = 32'h8000_0080; d_wdata[0] = ~pat;
    n = 0;
    @(negedge clk);
    while (!l2_write[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_write_seen", LW'(l2_write[0]), LW'(1));
    #2 rst_n[0] = 1'b0;
    i_m[0] = 0; d_m[0] = 0;
    #1;
    check("t6_rst_write", LW'({l2_read[0], l2_write[0]}), LW'(0));
    check("t6_rst_addr", LW'(l2_addr[0]), LW'(0));
    check("t6_rst_cnts", LW'({i_cnt[0], d_cnt[0]}), LW'(0));
    d_write[0] = 1'b0;
    #1 rst_n[0] = 1'b1;
    @(posedge clk); #1;
    i_read[0] = 1'b1; i_addr[0] = 32'h0000_0560;
    expect_txn(0, 1'b0, 32'h0000_0560);
    @(negedge clk);
    @(negedge clk);
    check("t6_post_rst_read", LW'({l2_read[0], l2_addr[0]}), LW'({1'b1, 32'h0000_0560}));
    serve(0, 1);
    i_read[0] = 1'b0;
    after_txn(0);

    // D priority: D wins three collisions, I is served once D drops.
    @(posedge clk); #1;
    i_read[1] = 1'b1; i_addr[1] = 32'h0000_0100;
    d_read[1] = 1'b1; d_addr[1] = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      expect_txn(1, k < 3, k < 3 ? 32'h0000_2000 : 32'h0000_0100);
      serve(1, 1);
      d_read[1] = (k < 2);
      if (k == 3) i_read[1] = 1'b0;
      after_txn(1);
    end

    // Drive the 3-bit D counter past all-ones.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      d_read[1] = 1'b1; d_addr[1] = 32'h0000_3000 + 32'(k * 32);
      expect_txn(1, 1'b1, 32'h0000_3000 + 32'(k * 32));
      serve(1, 0);
      d_read[1] = 1'b0;
      after_txn(1);
    end
    check("sat_d_cnt", LW'(d_cnt[1]), LW'(7));

    repeat (2) @(negedge clk);
    check("sb_empty", LW'(sb.size()), LW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
